// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns RV32 loads/stores into word-aligned req/ack memory transactions.
// Stalls the pipeline via busywait for at least 2 cycles per access; load result is presented in DONE.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        busywait,
   output logic        fault,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TIMEOUT_W-1:0] TIMER_LAST =
      TIMEOUT_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t                state_q, state_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [31:0]           addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [1:0]            lane_q, lane_d;
   logic [2:0]            f3_q, f3_d;
   logic [TIMEOUT_W-1:0]  timer_q, timer_d;
   logic                  timeout_q, timeout_d;
   logic [31:0]           load_data_q, load_data_d;

   logic        req;
   logic        f3_ok;
   logic        misalign;
   logic        bad;
   logic        go;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   function automatic logic [31:0] extract(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'd0:    extract = {{24{b[7]}}, b};
         3'd4:    extract = {24'h0, b};
         3'd1:    extract = {{16{h[15]}}, h};
         3'd5:    extract = {16'h0, h};
         default: extract = word;
      endcase
   endfunction

   // Request legality is decided purely from the current inputs while IDLE.
   always_comb begin
      req = mem_read | mem_write;
      if (mem_write)
         f3_ok = funct3 inside {3'd0, 3'd1, 3'd2};
      else
         f3_ok = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      misalign = ((funct3[1:0] == 2'd1) & addr[0]) |
                 ((funct3[1:0] == 2'd2) & (addr[1:0] != 2'b00));
      bad = req & ((mem_read & mem_write) | ~f3_ok | misalign);
      go  = req & ~bad;
   end

   always_comb begin
      case (funct3[1:0])
         2'd0: begin
            st_be    = 4'b0001 << addr[1:0];
            st_wdata = {4{wdata[7:0]}};
         end
         2'd1: begin
            st_be    = addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{wdata[15:0]}};
         end
         default: begin
            st_be    = 4'hF;
            st_wdata = wdata;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      lane_d      = lane_q;
      f3_d        = f3_q;
      timer_d     = timer_q;
      timeout_d   = timeout_q;
      load_data_d = load_data_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d     = S_ACCESS;
               req_d       = 1'b1;
               we_d        = mem_write;
               addr_d      = {addr[31:2], 2'b00};
               be_d        = mem_write ? st_be : 4'hF;
               wdata_d     = st_wdata;
               lane_d      = addr[1:0];
               f3_d        = funct3;
               timer_d     = '0;
               timeout_d   = 1'b0;
               load_data_d = '0;
            end
         end
         S_ACCESS: begin
            // An ack arriving in the expiry cycle still completes the access normally.
            if (dmem_ack) begin
               state_d     = S_DONE;
               req_d       = 1'b0;
               load_data_d = we_q ? 32'h0 : extract(dmem_rdata, lane_q, f3_q);
            end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
               state_d     = S_DONE;
               req_d       = 1'b0;
               timeout_d   = 1'b1;
               load_data_d = '0;
            end else if (TIMEOUT_EN) begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE: begin
            // Inputs still belong to the finished instruction, so never re-launch from here.
            state_d     = S_IDLE;
            timeout_d   = 1'b0;
            load_data_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         lane_q      <= '0;
         f3_q        <= '0;
         timer_q     <= '0;
         timeout_q   <= 1'b0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         lane_q      <= lane_d;
         f3_q        <= f3_d;
         timer_q     <= timer_d;
         timeout_q   <= timeout_d;
         load_data_q <= load_data_d;
      end
   end

   // busywait/fault are gated by rst so the pipeline is released the moment reset hits.
   assign busywait   = ~rst & (((state_q == S_IDLE) & go) | (state_q == S_ACCESS));
   assign fault      = ~rst & (((state_q == S_IDLE) & bad) | ((state_q == S_DONE) & timeout_q));
   assign load_data  = load_data_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests/load results queued at issue, checked on output.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] load_data;
   logic        busywait;
   logic        fault;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_req_t;

   exp_req_t    req_q[$];
   logic [31:0] load_q[$];

   int          n_checks = 0;
   int          n_pass   = 0;
   int          ack_delay = 0;
   logic [31:0] rd_word = 32'h0;
   bit          mem_en = 1'b1;
   bit          late_ack_req = 1'b0;

   mem_access_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .load_data  (load_data),
      .busywait   (busywait),
      .fault      (fault),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic bit model_bad(input bit rd, input bit wr, input logic [2:0] f3,
                                    input logic [31:0] a);
      bit ok;
      if (rd && wr) return 1'b1;
      if (wr) ok = (f3 <= 3'd2);
      else    ok = (f3 != 3'd3) && (f3 <= 3'd5);
      if (!ok) return 1'b1;
      if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
      if (f3[1:0] == 2'd2 && a[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] be;
      be = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (f3[1:0] == 2'd0) be[i] = (i == int'(a[1:0]));
         else if (f3[1:0] == 2'd1) be[i] = ((i / 2) == int'(a[1]));
         else be[i] = 1'b1;
      end
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3[1:0] == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (f3[1:0] == 2'd1) return {d[15:0], d[15:0]};
      return d;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * a[1:0]);
      case (f3)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd4:    return {24'h0, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd5:    return {16'h0, s[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory responder: checks each new request against the scoreboard, acks after ack_delay cycles.
   initial begin
      int       waited;
      bit       seen;
      exp_req_t e;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'hBAD0_BAD0;
      waited     = 0;
      seen       = 1'b0;
      forever begin
         @(negedge clk);
         if (dmem_ack) begin
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hBAD0_BAD0;
            seen       = 1'b0;
            waited     = 0;
         end else if (late_ack_req) begin
            dmem_ack     = 1'b1;
            dmem_rdata   = 32'h1234_5678;
            late_ack_req = 1'b0;
         end else if (mem_en && dmem_req) begin
            if (!seen) begin
               seen = 1'b1;
               chk("req_pending", 32'(req_q.size()), 32'd1);
               if (req_q.size() > 0) begin
                  e = req_q.pop_front();
                  chk("req_addr", dmem_addr, e.addr);
                  chk("req_we", 32'(dmem_we), 32'(e.we));
                  chk("req_be", 32'(dmem_be), 32'(e.be));
                  if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
               end
            end
            if (waited == ack_delay) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rd_word;
            end else begin
               waited++;
            end
         end
      end
   end

   task automatic clear_inputs();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      funct3    = 3'd0;
      addr      = 32'h0;
      wdata     = 32'h0;
   endtask

   // Called just after a rising edge with the DUT idle; returns just after a rising edge, idle.
   task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdw, input int dly);
      exp_req_t    e;
      int          stalls;
      logic [31:0] exp_ld;
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      rd_word   = rdw;
      ack_delay = dly;
      #1;
      if (model_bad(rd, wr, f3, a)) begin
         chk("bad_fault", 32'(fault), 32'd1);
         chk("bad_busy", 32'(busywait), 32'd0);
         chk("bad_load", load_data, 32'h0);
         @(posedge clk); #2;
         chk("bad_no_req", 32'(dmem_req), 32'd0);
         clear_inputs();
         return;
      end
      chk("busy_issue", 32'(busywait), 32'd1);
      chk("fault_issue", 32'(fault), 32'd0);
      e.addr  = {a[31:2], 2'b00};
      e.we    = wr;
      e.be    = wr ? model_be(f3, a) : 4'hF;
      e.wdata = model_wdata(f3, wd);
      req_q.push_back(e);
      load_q.push_back(wr ? 32'h0 : model_load(f3, a, rdw));
      stalls = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (!busywait) break;
         stalls++;
      end
      chk("stall_cycles", 32'(stalls), 32'(2 + dly));
      exp_ld = load_q.pop_front();
      chk("load_data", load_data, exp_ld);
      chk("done_fault", 32'(fault), 32'd0);
      chk("done_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #2;
      chk("no_relaunch", 32'(dmem_req), 32'd0);
      clear_inputs();
      #1;
      chk("idle_load", load_data, 32'h0);
   endtask

   initial begin
      int req_cycles;
      logic [2:0] f3;
      logic [31:0] a;
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_busy", 32'(busywait), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_be", 32'(dmem_be), 32'd0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_load", load_data, 32'h0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      run_op(1, 0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
      run_op(1, 0, 3'd0, 32'h0000_0203, 32'h0, 32'h8011_2233, 0);
      run_op(1, 0, 3'd4, 32'h0000_0203, 32'h0, 32'h8011_2233, 1);
      run_op(0, 1, 3'd1, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 0);
      run_op(1, 0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 0);
      run_op(1, 0, 3'd1, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 2);
      run_op(1, 0, 3'd5, 32'h0000_0100, 32'h0, 32'h1234_F00D, 0);
      run_op(0, 1, 3'd0, 32'h0000_0201, 32'h7777_775A, 32'h0, 1);
      run_op(0, 1, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 3);
      run_op(1, 1, 3'd2, 32'h0000_0200, 32'h0, 32'h0, 0);
      run_op(1, 0, 3'd3, 32'h0000_0200, 32'h0, 32'h0, 0);
      run_op(0, 1, 3'd4, 32'h0000_0200, 32'h0, 32'h0, 0);
      run_op(1, 0, 3'd1, 32'h0000_0201, 32'h0, 32'h0, 0);
      run_op(0, 1, 3'd2, 32'h0000_0206, 32'h0, 32'h0, 0);

      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 4))
            0:       f3 = 3'd0;
            1:       f3 = 3'd4;
            2:       f3 = 3'd1;
            3:       f3 = 3'd5;
            default: f3 = 3'd2;
         endcase
         a = $urandom;
         if (f3[1:0] == 2'd1) a[0] = 1'b0;
         if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
         run_op(1, 0, f3, a, 32'h0, $urandom, int'($urandom_range(0, 3)));
      end

      // Memory never answers: expect four request cycles then a timeout fault.
      mem_en    = 1'b0;
      mem_read  = 1'b1;
      funct3    = 3'd2;
      addr      = 32'h0000_0400;
      #1;
      chk("to_busy", 32'(busywait), 32'd1);
      req_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (!busywait) break;
         if (dmem_req) req_cycles++;
      end
      chk("to_req_cycles", 32'(req_cycles), 32'd4);
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_load", load_data, 32'h0);
      chk("to_req_done", 32'(dmem_req), 32'd0);
      @(posedge clk); #2;
      clear_inputs();
      #1;
      chk("to_fault_clr", 32'(fault), 32'd0);
      chk("to_idle_busy", 32'(busywait), 32'd0);

      // Reset two cycles into ACCESS, then a stray ack after release.
      @(posedge clk); #2;
      mem_read = 1'b1;
      funct3   = 3'd2;
      addr     = 32'h0000_0500;
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("mid_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_busy", 32'(busywait), 32'd0);
      chk("mid_rst_addr", dmem_addr, 32'h0);
      clear_inputs();
      @(posedge clk); #2;
      rst = 1'b0;
      late_ack_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         chk("late_ack_req", 32'(dmem_req), 32'd0);
         chk("late_ack_busy", 32'(busywait), 32'd0);
         chk("late_ack_load", load_data, 32'h0);
      end
      mem_en = 1'b1;
      run_op(1, 0, 3'd2, 32'h0000_0600, 32'h0, 32'hA5A5_0F0F, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
